// File: rtl/alu_sequencer.sv
// Drives a combinational 4-bit ALU through all eight opcodes for one latched operand pair.
// Each captured result is checked against a golden model and streamed out on a valid/ready port.
module alu_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] a_in,
   input  logic [3:0] b_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [4:0] alu_result,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [2:0] res_op,
   output logic [4:0] res_value,
   output logic       res_ok,
   output logic       mismatch,
   output logic [3:0] err_count
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_EMIT,
      S_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [3:0]    a_reg, a_next;
   logic [3:0]    b_reg, b_next;
   logic [2:0]    op_reg, op_next;
   logic [2:0]    res_op_reg, res_op_next;
   logic [4:0]    res_value_reg, res_value_next;
   logic          res_ok_reg, res_ok_next;
   logic          mismatch_reg, mismatch_next;
   logic [3:0]    err_reg, err_next;
   logic [4:0]    golden;

   // Reference behaviour of the ALU, operands zero-extended to the 5-bit result.
   always_comb begin
      golden = 5'd0;
      case (op_reg)
         3'd0: golden = {1'b0, a_reg} + {1'b0, b_reg};
         3'd1: golden = {1'b0, a_reg} - {1'b0, b_reg};
         3'd2: golden = {1'b0, a_reg & b_reg};
         3'd3: golden = {1'b0, a_reg | b_reg};
         3'd4: golden = {1'b0, a_reg ^ b_reg};
         3'd5: golden = {1'b0, ~a_reg};
         3'd6: golden = {4'd0, (a_reg < b_reg)};
         default: golden = 5'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         a_reg         <= 4'd0;
         b_reg         <= 4'd0;
         op_reg        <= 3'd0;
         res_op_reg    <= 3'd0;
         res_value_reg <= 5'd0;
         res_ok_reg    <= 1'b0;
         mismatch_reg  <= 1'b0;
         err_reg       <= 4'd0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         op_reg        <= op_next;
         res_op_reg    <= res_op_next;
         res_value_reg <= res_value_next;
         res_ok_reg    <= res_ok_next;
         mismatch_reg  <= mismatch_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      op_next        = op_reg;
      res_op_next    = res_op_reg;
      res_value_next = res_value_reg;
      res_ok_next    = res_ok_reg;
      mismatch_next  = mismatch_reg;
      err_next       = err_reg;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               a_next        = a_in;
               b_next        = b_in;
               op_next       = 3'd0;
               cnt_next      = '0;
               mismatch_next = 1'b0;
               err_next      = 4'd0;
               state_next    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_reg == CW'(SETTLE_CYCLES - 1)) begin
               cnt_next   = '0;
               state_next = S_CAPTURE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_CAPTURE: begin
            res_value_next = alu_result;
            res_op_next    = op_reg;
            res_ok_next    = (alu_result == golden);
            // At most eight beats per run, so the 4-bit counter never wraps.
            if (alu_result != golden) begin
               mismatch_next = 1'b1;
               err_next      = err_reg + 4'd1;
            end
            state_next = S_EMIT;
         end
         S_EMIT: begin
            if (res_ready) begin
               if (op_reg == 3'd7) begin
                  state_next = S_DONE;
               end else begin
                  op_next    = op_reg + 3'd1;
                  state_next = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign done      = (state_reg == S_DONE);
   assign res_valid = (state_reg == S_EMIT);
   assign alu_a     = a_reg;
   assign alu_b     = b_reg;
   assign alu_op    = op_reg;
   assign res_op    = res_op_reg;
   assign res_value = res_value_reg;
   assign res_ok    = res_ok_reg;
   assign mismatch  = mismatch_reg;
   assign err_count = err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU with optional op3 fault,
// hand-computed beat tables, backpressure, mid-run start, and reset abort.
module tb_alu_sequencer;

   localparam int S = 1;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a_in;
   logic [3:0] b_in;
   logic       busy;
   logic       done;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_op;
   logic [4:0] alu_result;
   logic       res_valid;
   logic       res_ready;
   logic [2:0] res_op;
   logic [4:0] res_value;
   logic       res_ok;
   logic       mismatch;
   logic [3:0] err_count;
   logic       fault;

   int n_run;
   int n_fail;

   alu_sequencer #(.SETTLE_CYCLES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a_in       (a_in),
      .b_in       (b_in),
      .busy       (busy),
      .done       (done),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_op     (res_op),
      .res_value  (res_value),
      .res_ok     (res_ok),
      .mismatch   (mismatch),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Device under exercise: the ALU itself, with an injectable fault on OR.
   always_comb begin
      alu_result = 5'd0;
      case (alu_op)
         3'd0: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
         3'd2: alu_result = {1'b0, alu_a & alu_b};
         3'd3: alu_result = fault ? 5'd0 : {1'b0, alu_a | alu_b};
         3'd4: alu_result = {1'b0, alu_a ^ alu_b};
         3'd5: alu_result = {1'b0, ~alu_a};
         3'd6: alu_result = {4'd0, (alu_a < alu_b)};
         default: alu_result = 5'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {busy, done, alu_a, alu_b, alu_op, res_valid, res_op,
                res_value, res_ok, mismatch, err_count}, 32'd0);
   endtask

   // One full run. Samples on the falling edge; cycle n is the n-th falling edge after the start edge.
   task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [0:7][4:0] exp,
                      input int bad_beat, input bit bp, input bit mid, input int abort_cyc,
                      input logic [3:0] exp_err);
      int cyc;
      int beat;
      int hold;
      int lat;
      bit armed;
      bit fin;
      cyc   = 0;
      beat  = 0;
      hold  = 0;
      armed = 1'b0;
      fin   = 1'b0;
      start     = 1'b1;
      a_in      = a;
      b_in      = b;
      res_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_in  = ~a;
      b_in  = ~b;
      cyc   = 1;
      chk("busy_after_start", busy, 1);
      chk("alu_a_latched", alu_a, a);
      chk("alu_b_latched", alu_b, b);
      while (!fin && cyc < 300) begin
         if (start) start = 1'b0;
         if (cyc == abort_cyc) begin
            chk("abort_in_settle", {res_valid, alu_op}, {1'b0, 3'd5});
            rst_n = 1'b0;
            @(negedge clk);
            chk_all_zero("reset_mid_run");
            rst_n = 1'b1;
            @(negedge clk);
            chk("no_done_after_abort", {done, busy}, 2'b00);
            return;
         end
         if (bp && armed && res_ready && !res_valid) res_ready = 1'b0;
         if (!res_ready && hold == 5) res_ready = 1'b1;
         if (!res_ready && res_valid) begin
            hold++;
            chk("bp_beat_stable", {res_op, res_value}, {3'd2, 5'd1});
            chk("bp_alu_op_held", alu_op, 3'd2);
         end
         if (res_valid && res_ready) begin
            chk("beat_op", res_op, beat[2:0]);
            chk("beat_value", res_value, exp[beat]);
            chk("beat_ok", res_ok, (beat != bad_beat));
            lat = beat * (S + 2) + S + 2 + ((bp && beat >= 2) ? 5 : 0);
            chk("beat_latency", cyc, lat);
            if (bp && beat == 1) armed = 1'b1;
            if (mid && beat == 4) begin
               start = 1'b1;
               a_in  = 4'd9;
               b_in  = 4'd2;
            end
            beat++;
         end
         if (done) begin
            chk("done_cycle", cyc, 8 * (S + 2) + 1 + (bp ? 5 : 0));
            chk("beats_seen", beat, 8);
            chk("final_errors", {mismatch, err_count}, {(exp_err != 4'd0), exp_err});
            chk("busy_in_done", busy, 0);
            fin   = 1'b1;
            start = 1'b1;
            a_in  = 4'd6;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("run_finished", fin, 1);
      if (bp) chk("bp_hold_cycles", hold, 5);
      @(negedge clk);
      chk("start_in_done_ignored", {busy, done}, 2'b00);
      start = 1'b0;
      @(negedge clk);
      chk("idle_hold", {busy, done, mismatch, err_count}, {2'b00, (exp_err != 4'd0), exp_err});
   endtask

   initial begin
      n_run     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      a_in      = 4'd0;
      b_in      = 4'd0;
      res_ready = 1'b1;
      fault     = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset_state");
      rst_n = 1'b1;
      @(negedge clk);

      run(4'd3, 4'd5, {5'd8, 5'd30, 5'd1, 5'd7, 5'd6, 5'd12, 5'd1, 5'd0}, -1, 1'b0, 1'b0, 0, 4'd0);
      fault = 1'b1;
      run(4'd3, 4'd5, {5'd8, 5'd30, 5'd1, 5'd0, 5'd6, 5'd12, 5'd1, 5'd0}, 3, 1'b0, 1'b0, 0, 4'd1);
      fault = 1'b0;
      run(4'd3, 4'd5, {5'd8, 5'd30, 5'd1, 5'd7, 5'd6, 5'd12, 5'd1, 5'd0}, -1, 1'b1, 1'b0, 0, 4'd0);
      run(4'd15, 4'd15, {5'd30, 5'd0, 5'd15, 5'd15, 5'd0, 5'd0, 5'd0, 5'd0}, -1, 1'b0, 1'b0, 0, 4'd0);
      run(4'd0, 4'd1, {5'd1, 5'd31, 5'd0, 5'd1, 5'd1, 5'd15, 5'd1, 5'd0}, -1, 1'b0, 1'b0, 0, 4'd0);
      run(4'd3, 4'd5, {5'd8, 5'd30, 5'd1, 5'd7, 5'd6, 5'd12, 5'd1, 5'd0}, -1, 1'b0, 1'b1, 0, 4'd0);
      run(4'd3, 4'd5, {5'd8, 5'd30, 5'd1, 5'd7, 5'd6, 5'd12, 5'd1, 5'd0}, -1, 1'b0, 1'b0, 16, 4'd0);
      run(4'd10, 4'd4, {5'd14, 5'd6, 5'd0, 5'd14, 5'd14, 5'd5, 5'd0, 5'd0}, -1, 1'b0, 1'b0, 0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
